// File: rtl/signed_divider_seq_if.sv
// Request/result bundle for the sequential signed divider.
// The master side issues start with operands; the slave side returns busy/done and the results.
interface signed_divider_seq_if;
  logic       start;
  logic [4:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [4:0] quotient;
  logic [4:0] remainder;
  logic       dbz;
  logic       ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/signed_divider_seq.sv
// 5-bit signed / 3-bit sign-magnitude restoring divider: done 8 cycles after start (2 for divide-by-zero).
// No backpressure: start is sampled only in IDLE and ignored while busy; results hold until the next done.
module signed_divider_seq (
  input  logic                 clk,
  input  logic                 rst_n,
  signed_divider_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIV  = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] dividend_q, dividend_d;
  logic [2:0] divisor_q, divisor_d;
  logic [4:0] dvd_mag_q, dvd_mag_d;
  logic [1:0] dvs_mag_q, dvs_mag_d;
  logic       dvd_neg_q, dvd_neg_d;
  logic       dvs_neg_q, dvs_neg_d;
  logic [1:0] rem_q, rem_d;
  logic [4:0] quo_q, quo_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] quotient_q, quotient_d;
  logic [4:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;
  logic       ovf_q, ovf_d;

  logic [2:0] partial;
  logic       quo_neg;

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    dvd_mag_d   = dvd_mag_q;
    dvs_mag_d   = dvs_mag_q;
    dvd_neg_d   = dvd_neg_q;
    dvs_neg_d   = dvs_neg_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    partial     = {rem_q, dvd_mag_q[cnt_q]};
    quo_neg     = (dvd_neg_q ^ dvs_neg_q) && (quo_q != 5'd0);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dividend_d = bus.dividend;
          divisor_d  = bus.divisor;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        // -16 negates to 5'b10000, which is the correct unsigned magnitude 16
        dvd_neg_d = dividend_q[4];
        dvd_mag_d = dividend_q[4] ? (~dividend_q + 5'd1) : dividend_q;
        dvs_neg_d = divisor_q[2];
        dvs_mag_d = divisor_q[1:0];
        rem_d     = 2'd0;
        quo_d     = 5'd0;
        cnt_d     = 3'd4;
        if (divisor_q[1:0] == 2'd0) begin
          quotient_d  = 5'd0;
          remainder_d = dividend_q;
          dbz_d       = 1'b1;
          ovf_d       = 1'b0;
          state_d     = DONE;
        end else begin
          state_d = DIV;
        end
      end

      DIV: begin
        // partial remainder stays below the divisor, so two bits hold it between steps
        if (partial >= {1'b0, dvs_mag_q}) begin
          rem_d        = 2'(partial - {1'b0, dvs_mag_q});
          quo_d[cnt_q] = 1'b1;
        end else begin
          rem_d        = partial[1:0];
          quo_d[cnt_q] = 1'b0;
        end
        if (cnt_q == 3'd0) begin
          state_d = SIGN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      SIGN: begin
        dbz_d = 1'b0;
        if ((quo_q == 5'b10000) && !quo_neg) begin
          quotient_d  = 5'b01111;
          remainder_d = 5'd0;
          ovf_d       = 1'b1;
        end else begin
          quotient_d  = quo_neg ? (~quo_q + 5'd1) : quo_q;
          remainder_d = (dvd_neg_q && (rem_q != 2'd0)) ? (~{3'b000, rem_q} + 5'd1)
                                                       : {3'b000, rem_q};
          ovf_d       = 1'b0;
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dividend_q  <= 5'd0;
      divisor_q   <= 3'd0;
      dvd_mag_q   <= 5'd0;
      dvs_mag_q   <= 2'd0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      rem_q       <= 2'd0;
      quo_q       <= 5'd0;
      cnt_q       <= 3'd0;
      quotient_q  <= 5'd0;
      remainder_q <= 5'd0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      dvd_mag_q   <= dvd_mag_d;
      dvs_mag_q   <= dvs_mag_d;
      dvd_neg_q   <= dvd_neg_d;
      dvs_neg_q   <= dvs_neg_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

  a_done_busy: assert property (@(posedge clk) disable iff (!rst_n) bus.done |-> bus.busy);
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) (state_q == DIV) |-> (cnt_q <= 3'd4));

endmodule

// File: tb/tb_signed_divider_seq.sv
// Scoreboard bench for signed_divider_seq: reference results from integer division, popped on done.
// Covers reset, spec vectors, random operands, start-while-busy, held start and mid-operation reset.
module tb_signed_divider_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  signed_divider_seq_if bus_if ();

  signed_divider_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [11:0] res;
    int          lat;
    logic [4:0]  a;
    logic [2:0]  b;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Truncating signed division; the only quotient that cannot fit is -16 / -1
  function automatic exp_t model(input logic [4:0] a, input logic [2:0] b);
    exp_t e;
    int   sa, mb, sb, q, r;
    logic ov;
    sa  = int'($signed(a));
    mb  = int'(b[1:0]);
    sb  = b[2] ? -mb : mb;
    e.a = a;
    e.b = b;
    if (mb == 0) begin
      e.res = {5'd0, a, 1'b1, 1'b0};
      e.lat = 2;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      ov = 1'b0;
      if (q == 16) begin
        q  = 15;
        r  = 0;
        ov = 1'b1;
      end
      e.res = {q[4:0], r[4:0], 1'b0, ov};
      e.lat = 8;
    end
    return e;
  endfunction

  function automatic logic [11:0] obs();
    return {bus_if.quotient, bus_if.remainder, bus_if.dbz, bus_if.ovf};
  endfunction

  // Issue one operation from IDLE; operands are scrambled right after capture
  task automatic launch(input logic [4:0] a, input logic [2:0] b);
    @(posedge clk); #1;
    bus_if.dividend = a;
    bus_if.divisor  = b;
    bus_if.start    = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk); #1;
    bus_if.start    = 1'b0;
    bus_if.dividend = 5'($urandom);
    bus_if.divisor  = 3'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus_if.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   lat;
    rst_n           = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.dividend = 5'd0;
    bus_if.divisor  = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus_if.busy, bus_if.done, obs()} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b res=%b, want all zero",
               bus_if.busy, bus_if.done, obs());
    end
    // start presented together with the release of reset must be taken at once
    rst_n           = 1'b1;
    bus_if.start    = 1'b1;
    bus_if.dividend = 5'd13;
    bus_if.divisor  = 3'b011;
    sb_q.push_back(model(5'd13, 3'b011));
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n_cmp++;
    if (bus_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL first_start: got busy=%b, want 1", bus_if.busy);
    end
    wait_done(lat);
    e = sb_q.pop_front();
    n_cmp++;
    if (lat !== e.lat || obs() !== e.res) begin
      n_err++;
      $display("FAIL first_op: got lat=%0d res=%b, want lat=%0d res=%b", lat, obs(), e.lat, e.res);
    end
  endtask

  task automatic test_vectors();
    logic [4:0] ta [6];
    logic [2:0] tb [6];
    logic [4:0] a;
    logic [2:0] b;
    exp_t       e;
    int         lat;
    ta = '{5'b01101, 5'b11001, 5'b11111, 5'b10000, 5'b00110, 5'b01001};
    tb = '{3'b011,   3'b010,   3'b011,   3'b101,   3'b111,   3'b100};
    for (int i = 0; i < 46; i++) begin
      if (i < 6) begin
        a = ta[i];
        b = tb[i];
      end else begin
        a = 5'($urandom);
        b = 3'($urandom);
      end
      launch(a, b);
      wait_done(lat);
      e = sb_q.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_err++;
        $display("FAIL latency a=%b b=%b: got %0d, want %0d", e.a, e.b, lat, e.lat);
      end
      n_cmp++;
      if (obs() !== e.res) begin
        n_err++;
        $display("FAIL result a=%b b=%b: got q=%b r=%b dbz=%b ovf=%b, want %b",
                 e.a, e.b, bus_if.quotient, bus_if.remainder, bus_if.dbz, bus_if.ovf, e.res);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || obs() !== e.res) begin
        n_err++;
        $display("FAIL hold a=%b b=%b: got done=%b busy=%b res=%b, want done=0 busy=0 res=%b",
                 e.a, e.b, bus_if.done, bus_if.busy, obs(), e.res);
      end
    end
  endtask

  task automatic test_busy_start();
    exp_t        e;
    int          ndone, lat;
    logic [11:0] res;
    ndone = 0;
    lat   = 0;
    res   = 12'd0;
    @(posedge clk); #1;
    bus_if.dividend = 5'b10011;
    bus_if.divisor  = 3'b010;
    bus_if.start    = 1'b1;
    sb_q.push_back(model(5'b10011, 3'b010));
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      if (bus_if.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          lat = c;
          res = obs();
        end
      end
      bus_if.start    = (c >= 3 && c <= 6);
      bus_if.dividend = 5'($urandom);
      bus_if.divisor  = 3'b001;
      @(posedge clk); #1;
    end
    bus_if.start = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (ndone !== 1) begin
      n_err++;
      $display("FAIL busy_start_pulses: got %0d done pulses, want 1", ndone);
    end
    n_cmp++;
    if (lat !== 8 || res !== e.res) begin
      n_err++;
      $display("FAIL busy_start_result: got lat=%0d res=%b, want lat=8 res=%b", lat, res, e.res);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        ea, eb;
    int          n;
    int          dcyc [4];
    logic [11:0] dres [4];
    n = 0;
    for (int k = 0; k < 4; k++) begin
      dcyc[k] = 0;
      dres[k] = 12'd0;
    end
    @(posedge clk); #1;
    bus_if.dividend = 5'b01111;
    bus_if.divisor  = 3'b110;
    bus_if.start    = 1'b1;
    sb_q.push_back(model(5'b01111, 3'b110));
    @(posedge clk); #1;
    bus_if.dividend = 5'b10100;
    bus_if.divisor  = 3'b011;
    sb_q.push_back(model(5'b10100, 3'b011));
    for (int c = 1; c <= 30; c++) begin
      if (bus_if.done === 1'b1) begin
        if (n < 4) begin
          dcyc[n] = c;
          dres[n] = obs();
        end
        n++;
      end
      if (c == 9) begin
        n_cmp++;
        if (bus_if.busy !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_idle_gap: got busy=%b in cycle 9, want 0", bus_if.busy);
        end
      end
      if (c == 10) bus_if.start = 1'b0;
      @(posedge clk); #1;
    end
    ea = sb_q.pop_front();
    eb = sb_q.pop_front();
    n_cmp++;
    if (n !== 2 || dcyc[0] !== 8 || dcyc[1] !== 17) begin
      n_err++;
      $display("FAIL b2b_timing: got %0d pulses at %0d,%0d, want 2 at 8,17", n, dcyc[0], dcyc[1]);
    end
    n_cmp++;
    if (dres[0] !== ea.res || dres[1] !== eb.res) begin
      n_err++;
      $display("FAIL b2b_results: got %b,%b, want %b,%b", dres[0], dres[1], ea.res, eb.res);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   lat, ndone;
    launch(5'b01110, 3'b111);
    wait_done(lat);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.res) begin
      n_err++;
      $display("FAIL pre_reset_op: got %b, want %b", obs(), e.res);
    end
    @(posedge clk); #1;
    bus_if.dividend = 5'b01101;
    bus_if.divisor  = 3'b001;
    bus_if.start    = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus_if.busy, bus_if.done, obs()} !== 14'd0) begin
      n_err++;
      $display("FAIL mid_reset_clear: got busy=%b done=%b res=%b, want all zero",
               bus_if.busy, bus_if.done, obs());
    end
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_err++;
      $display("FAIL mid_reset_abort: got %0d done pulses, want 0", ndone);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
